// File: rtl/serial_adder_sequencer.sv
// Nibble-serial adder: one 4-bit adder reused over NIBBLES cycles, LSB nibble first.
// sum/carry_out are registered and change only on entry to FINISH.
//
// state  | meaning
// IDLE   | waiting for start; operands captured when start is seen
// ADD    | one nibble per cycle through the shared adder, NIBBLES cycles
// FINISH | done pulse; final sum/carry_out already presented
module serial_adder_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   alpha,
    input  logic [4*NIBBLES-1:0]   beta,
    input  logic                   carry_in,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   carry_out
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        FINISH
    } state_t;

    state_t          state;
    logic [IW-1:0]   index;
    logic            carry_q;
    logic [W-1:0]    a_sh;
    logic [W-1:0]    b_sh;
    logic [W-1:0]    res_sh;
    logic [4:0]      nib;

    assign nib = {1'b0, a_sh[3:0]} + {1'b0, b_sh[3:0]} + {4'd0, carry_q};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            index     <= '0;
            carry_q   <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh    <= alpha;
                        b_sh    <= beta;
                        carry_q <= carry_in;
                        index   <= '0;
                        busy    <= 1'b1;
                        state   <= ADD;
                    end
                end
                ADD: begin
                    // result nibbles enter from the top so nibble 0 ends at bit 0
                    a_sh    <= a_sh >> 4;
                    b_sh    <= b_sh >> 4;
                    res_sh  <= {nib[3:0], res_sh[W-1:4]};
                    carry_q <= nib[4];
                    index   <= index + 1'b1;
                    if (index == LAST) begin
                        sum       <= {nib[3:0], res_sh[W-1:4]};
                        carry_out <= nib[4];
                        done      <= 1'b1;
                        state     <= FINISH;
                    end
                end
                FINISH: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
